// File: rtl/psum_wb_scheduler.sv
// Layer sequencer for the ReLU/guard write-back engine: arbitrates two ping-pong psum banks
// between the PE-array producer and the write-back engine and advances destination bases per tile.
module psum_wb_scheduler #(
   parameter int unsigned CNT_W        = 8,
   parameter int unsigned FM_ADDR_W    = 16,
   parameter int unsigned GUARD_ADDR_W = 14
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    layer_valid,
   output logic                    layer_ready,
   input  logic [CNT_W-1:0]        layer_tiles_i,
   input  logic [7:0]              w_num_i,
   input  logic [7:0]              h_num_i,
   input  logic                    bit_mode_i,
   input  logic [FM_ADDR_W-1:0]    fm_base_i,
   input  logic [GUARD_ADDR_W-1:0] guard_base_i,
   output logic                    layer_done,
   output logic                    prod_ready,
   output logic                    prod_bank,
   input  logic                    prod_done,
   output logic                    wb_valid,
   input  logic                    wb_ready,
   input  logic                    wb_finish,
   output logic [7:0]              wb_w_num,
   output logic [7:0]              wb_h_num,
   output logic                    wb_bit_mode,
   output logic                    wb_bank,
   output logic [FM_ADDR_W-1:0]    wb_fm_base,
   output logic [GUARD_ADDR_W-1:0] wb_guard_base
);

   typedef enum logic [1:0] {StIdle, StIssue, StRun, StDone} state_e;

   state_e                  state_q, state_d;
   logic [1:0]              full_q, full_d;
   logic                    prod_ptr_q, wb_ptr_q;
   logic [CNT_W-1:0]        tiles_q, issued_cnt_q, done_cnt_q;
   logic [7:0]              w_q, h_q;
   logic                    bit_mode_q;
   logic [15:0]             pix_q;
   logic [FM_ADDR_W-1:0]    fm_step_q, fm_base_q;
   logic [GUARD_ADDR_W-1:0] guard_step_q, guard_base_q;
   logic                    wb_valid_q, wb_valid_d, layer_done_q;

   logic                    active, accept, prod_fire, wb_fire, fin, last_tile;
   logic [CNT_W:0]          done_inc;
   logic [FM_ADDR_W-1:0]    pix_fm, pix_x3, pix_x6;

   assign active      = (state_q == StIssue) || (state_q == StRun);
   assign layer_ready = (state_q == StIdle);
   assign accept      = layer_valid && layer_ready;
   assign prod_ready  = active && !full_q[prod_ptr_q] && (issued_cnt_q < tiles_q);
   assign prod_fire   = prod_done && prod_ready;
   assign wb_fire     = wb_valid_q && wb_ready;
   assign fin         = (state_q == StRun) && wb_finish;
   assign done_inc    = {1'b0, done_cnt_q} + {{CNT_W{1'b0}}, 1'b1};
   assign last_tile   = (done_inc == {1'b0, tiles_q});

   // Step arithmetic is done at address width, so wrap is implicit.
   assign pix_fm = FM_ADDR_W'(pix_q);
   assign pix_x3 = pix_fm + (pix_fm << 1);
   assign pix_x6 = pix_x3 << 1;

   always_comb begin
      state_d    = state_q;
      full_d     = full_q;
      wb_valid_d = 1'b0;
      // Producer and engine always touch different banks, so both updates may land together.
      if (prod_fire) full_d[prod_ptr_q] = 1'b1;
      if (fin)       full_d[wb_ptr_q]   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               full_d  = 2'b00;
               state_d = (layer_tiles_i == '0) ? StDone : StIssue;
            end
         end
         StIssue: begin
            wb_valid_d = full_q[wb_ptr_q] && !wb_fire;
            if (wb_fire) state_d = StRun;
         end
         StRun: begin
            if (fin) state_d = last_tile ? StDone : StIssue;
         end
         StDone: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         full_q       <= 2'b00;
         prod_ptr_q   <= 1'b0;
         wb_ptr_q     <= 1'b0;
         tiles_q      <= '0;
         issued_cnt_q <= '0;
         done_cnt_q   <= '0;
         w_q          <= '0;
         h_q          <= '0;
         bit_mode_q   <= 1'b0;
         pix_q        <= '0;
         fm_step_q    <= '0;
         fm_base_q    <= '0;
         guard_step_q <= '0;
         guard_base_q <= '0;
         wb_valid_q   <= 1'b0;
         layer_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         full_q       <= full_d;
         wb_valid_q   <= wb_valid_d;
         layer_done_q <= (state_q == StDone);
         // Steps follow pix_q one cycle later; settled long before the first finish.
         fm_step_q    <= bit_mode_q ? pix_x3 : pix_x6;
         guard_step_q <= bit_mode_q ? '0 : GUARD_ADDR_W'(pix_q);
         if (accept) begin
            tiles_q      <= layer_tiles_i;
            w_q          <= w_num_i;
            h_q          <= h_num_i;
            bit_mode_q   <= bit_mode_i;
            fm_base_q    <= fm_base_i;
            guard_base_q <= guard_base_i;
            pix_q        <= {8'h00, w_num_i} * {8'h00, h_num_i};
            prod_ptr_q   <= 1'b0;
            wb_ptr_q     <= 1'b0;
            issued_cnt_q <= '0;
            done_cnt_q   <= '0;
         end else begin
            if (prod_fire) begin
               prod_ptr_q   <= ~prod_ptr_q;
               issued_cnt_q <= issued_cnt_q + CNT_W'(1);
            end
            if (fin) begin
               wb_ptr_q     <= ~wb_ptr_q;
               done_cnt_q   <= done_cnt_q + CNT_W'(1);
               fm_base_q    <= fm_base_q + fm_step_q;
               guard_base_q <= guard_base_q + guard_step_q;
            end
         end
      end
   end

   assign layer_done    = layer_done_q;
   assign prod_bank     = prod_ptr_q;
   assign wb_valid      = wb_valid_q;
   assign wb_w_num      = w_q;
   assign wb_h_num      = h_q;
   assign wb_bit_mode   = bit_mode_q;
   assign wb_bank       = wb_ptr_q;
   assign wb_fm_base    = fm_base_q;
   assign wb_guard_base = guard_base_q;

endmodule

// File: tb/tb_psum_wb_scheduler.sv
// Scoreboard bench for psum_wb_scheduler: expected tiles are queued at producer hand-off and
// compared when the scheduler raises its write-back request.
module tb_psum_wb_scheduler;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        layer_valid = 1'b0;
   logic        layer_ready;
   logic [7:0]  layer_tiles_i = '0;
   logic [7:0]  w_num_i = '0;
   logic [7:0]  h_num_i = '0;
   logic        bit_mode_i = 1'b0;
   logic [15:0] fm_base_i = '0;
   logic [13:0] guard_base_i = '0;
   logic        layer_done;
   logic        prod_ready;
   logic        prod_bank;
   logic        prod_done = 1'b0;
   logic        wb_valid;
   logic        wb_ready = 1'b0;
   logic        wb_finish = 1'b0;
   logic [7:0]  wb_w_num;
   logic [7:0]  wb_h_num;
   logic        wb_bit_mode;
   logic        wb_bank;
   logic [15:0] wb_fm_base;
   logic [13:0] wb_guard_base;

   psum_wb_scheduler dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .layer_valid   (layer_valid),
      .layer_ready   (layer_ready),
      .layer_tiles_i (layer_tiles_i),
      .w_num_i       (w_num_i),
      .h_num_i       (h_num_i),
      .bit_mode_i    (bit_mode_i),
      .fm_base_i     (fm_base_i),
      .guard_base_i  (guard_base_i),
      .layer_done    (layer_done),
      .prod_ready    (prod_ready),
      .prod_bank     (prod_bank),
      .prod_done     (prod_done),
      .wb_valid      (wb_valid),
      .wb_ready      (wb_ready),
      .wb_finish     (wb_finish),
      .wb_w_num      (wb_w_num),
      .wb_h_num      (wb_h_num),
      .wb_bit_mode   (wb_bit_mode),
      .wb_bank       (wb_bank),
      .wb_fm_base    (wb_fm_base),
      .wb_guard_base (wb_guard_base)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        bank;
      logic [15:0] fm;
      logic [13:0] guard;
   } exp_t;

   exp_t        sb[$];
   int          n_cmp = 0;
   int          n_err = 0;

   logic        m_prod_ptr;
   logic [15:0] m_fm_next, m_fm_step;
   logic [13:0] m_g_next, m_g_step;
   logic [7:0]  m_w, m_h;
   logic        m_bm;

   task automatic apply_reset();
      layer_valid = 1'b0;
      prod_done   = 1'b0;
      wb_ready    = 1'b0;
      wb_finish   = 1'b0;
      rst_n       = 1'b0;
      sb.delete();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic start_layer(input int tiles, input int w, input int h, input bit bm,
                              input int fm, input int g);
      int p;
      layer_tiles_i = 8'(tiles);
      w_num_i       = 8'(w);
      h_num_i       = 8'(h);
      bit_mode_i    = bm;
      fm_base_i     = 16'(fm);
      guard_base_i  = 14'(g);
      layer_valid   = 1'b1;
      n_cmp++;
      if (layer_ready !== 1'b1) begin
         n_err++;
         $display("FAIL start_ready: got %b expected 1", layer_ready);
      end
      @(negedge clk);
      layer_valid = 1'b0;
      n_cmp++;
      if (layer_ready !== 1'b0) begin
         n_err++;
         $display("FAIL ready_drop: got %b expected 0", layer_ready);
      end
      p          = w * h;
      m_fm_step  = 16'(bm ? p * 3 : p * 6);
      m_g_step   = 14'(bm ? 0 : p);
      m_fm_next  = 16'(fm);
      m_g_next   = 14'(g);
      m_prod_ptr = 1'b0;
      m_w        = 8'(w);
      m_h        = 8'(h);
      m_bm       = bm;
   endtask

   task automatic produce();
      int t = 0;
      while (prod_ready !== 1'b1 && t < 50) begin
         @(negedge clk);
         t++;
      end
      n_cmp++;
      if (prod_ready !== 1'b1) begin
         n_err++;
         $display("FAIL prod_ready_timeout: got %b expected 1 within 50 cycles", prod_ready);
         return;
      end
      n_cmp++;
      if (prod_bank !== m_prod_ptr) begin
         n_err++;
         $display("FAIL prod_bank: got %b expected %b", prod_bank, m_prod_ptr);
      end
      sb.push_back({m_prod_ptr, m_fm_next, m_g_next});
      m_fm_next  = m_fm_next + m_fm_step;
      m_g_next   = m_g_next + m_g_step;
      m_prod_ptr = ~m_prod_ptr;
      prod_done  = 1'b1;
      @(negedge clk);
      prod_done = 1'b0;
   endtask

   task automatic consume(input int hold, input bit spurious);
      exp_t e;
      int   t = 0;
      while (wb_valid !== 1'b1 && t < 50) begin
         @(negedge clk);
         t++;
      end
      n_cmp++;
      if (wb_valid !== 1'b1) begin
         n_err++;
         $display("FAIL wb_valid_timeout: got %b expected 1 within 50 cycles", wb_valid);
         return;
      end
      n_cmp++;
      if (sb.size() == 0) begin
         n_err++;
         $display("FAIL sb_empty: got wb_valid with 0 queued tiles, expected none");
         return;
      end
      e = sb.pop_front();
      n_cmp++;
      if ({wb_bank, wb_fm_base, wb_guard_base} !== e) begin
         n_err++;
         $display("FAIL tile_fields: got bank=%0d fm=%h guard=%h expected bank=%0d fm=%h guard=%h",
                  wb_bank, wb_fm_base, wb_guard_base, e.bank, e.fm, e.guard);
      end
      n_cmp++;
      if ({wb_w_num, wb_h_num, wb_bit_mode} !== {m_w, m_h, m_bm}) begin
         n_err++;
         $display("FAIL tile_dims: got w=%0d h=%0d bm=%b expected w=%0d h=%0d bm=%b",
                  wb_w_num, wb_h_num, wb_bit_mode, m_w, m_h, m_bm);
      end
      for (int i = 0; i < hold; i++) begin
         wb_finish = spurious && (i == 1);
         @(negedge clk);
         n_cmp++;
         if (wb_valid !== 1'b1 || {wb_bank, wb_fm_base, wb_guard_base} !== e ||
             {wb_w_num, wb_h_num, wb_bit_mode} !== {m_w, m_h, m_bm}) begin
            n_err++;
            $display("FAIL hold_stable: got valid=%b bank=%0d fm=%h guard=%h expected 1/%0d/%h/%h",
                     wb_valid, wb_bank, wb_fm_base, wb_guard_base, e.bank, e.fm, e.guard);
         end
      end
      wb_finish = 1'b0;
      wb_ready  = 1'b1;
      @(negedge clk);
      wb_ready = 1'b0;
      n_cmp++;
      if (wb_valid !== 1'b0) begin
         n_err++;
         $display("FAIL valid_drop: got %b expected 0", wb_valid);
      end
   endtask

   task automatic finish_tile();
      wb_finish = 1'b1;
      @(negedge clk);
      wb_finish = 1'b0;
   endtask

   task automatic wait_done();
      int t = 0;
      while (layer_done !== 1'b1 && t < 20) begin
         @(negedge clk);
         t++;
      end
      n_cmp++;
      if (layer_done !== 1'b1) begin
         n_err++;
         $display("FAIL layer_done_timeout: got %b expected 1 within 20 cycles", layer_done);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({layer_ready, layer_done, wb_valid, prod_ready, prod_bank, wb_bank, wb_bit_mode}
          !== 7'b1000000) begin
         n_err++;
         $display("FAIL reset_ctrl: got rdy=%b done=%b val=%b prdy=%b pb=%b wbb=%b bm=%b",
                  layer_ready, layer_done, wb_valid, prod_ready, prod_bank, wb_bank,
                  wb_bit_mode);
      end
      n_cmp++;
      if ({wb_fm_base, wb_guard_base, wb_w_num, wb_h_num} !== '0) begin
         n_err++;
         $display("FAIL reset_data: got fm=%h guard=%h w=%0d h=%0d expected all 0",
                  wb_fm_base, wb_guard_base, wb_w_num, wb_h_num);
      end
      apply_reset();
   endtask

   task automatic test_single_tile();
      apply_reset();
      start_layer(1, 4, 2, 1'b0, 'h100, 'h20);
      produce();
      consume(0, 1'b0);
      finish_tile();
      wait_done();
      n_cmp++;
      if (wb_fm_base !== 16'h0130 || wb_guard_base !== 14'h0028) begin
         n_err++;
         $display("FAIL final_bases: got fm=%h guard=%h expected 0130/0028",
                  wb_fm_base, wb_guard_base);
      end
      @(negedge clk);
      n_cmp++;
      if (layer_done !== 1'b0) begin
         n_err++;
         $display("FAIL done_pulse_width: got %b expected 0", layer_done);
      end
   endtask

   task automatic test_bank_sequence();
      apply_reset();
      start_layer(3, 2, 2, 1'b1, 0, 'h15);
      produce();
      produce();
      n_cmp++;
      if (prod_ready !== 1'b0) begin
         n_err++;
         $display("FAIL both_full_stall: got prod_ready=%b expected 0", prod_ready);
      end
      consume(0, 1'b0);
      wb_finish = 1'b1;
      n_cmp++;
      if (prod_ready !== 1'b0) begin
         n_err++;
         $display("FAIL ready_before_finish: got %b expected 0", prod_ready);
      end
      @(negedge clk);
      wb_finish = 1'b0;
      n_cmp++;
      if (prod_ready !== 1'b1 || prod_bank !== 1'b0) begin
         n_err++;
         $display("FAIL ready_after_finish: got rdy=%b bank=%b expected 1/0", prod_ready,
                  prod_bank);
      end
      produce();
      consume(0, 1'b0);
      finish_tile();
      consume(0, 1'b0);
      finish_tile();
      wait_done();
      n_cmp++;
      if (wb_fm_base !== 16'd36 || wb_guard_base !== 14'h15) begin
         n_err++;
         $display("FAIL seq_final_bases: got fm=%0d guard=%h expected 36/15", wb_fm_base,
                  wb_guard_base);
      end
   endtask

   task automatic test_both_full();
      apply_reset();
      start_layer(2, 3, 1, 1'b0, 'h40, 'h4);
      produce();
      produce();
      consume(0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_cmp++;
         if (prod_ready !== 1'b0) begin
            n_err++;
            $display("FAIL stall_in_run: got prod_ready=%b expected 0", prod_ready);
         end
      end
      finish_tile();
      n_cmp++;
      if (wb_valid !== 1'b0) begin
         n_err++;
         $display("FAIL latency_early: got wb_valid=%b expected 0 one cycle after finish",
                  wb_valid);
      end
      @(negedge clk);
      n_cmp++;
      if (wb_valid !== 1'b1 || wb_bank !== 1'b1) begin
         n_err++;
         $display("FAIL latency_two: got valid=%b bank=%b expected 1/1", wb_valid, wb_bank);
      end
      consume(0, 1'b0);
      finish_tile();
      wait_done();
   endtask

   task automatic test_ready_stall();
      apply_reset();
      start_layer(2, 5, 3, 1'b0, 0, 0);
      produce();
      consume(5, 1'b1);
      finish_tile();
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if (layer_done !== 1'b0) begin
            n_err++;
            $display("FAIL spurious_counted: got layer_done=%b expected 0 after tile 1",
                     layer_done);
         end
         @(negedge clk);
      end
      produce();
      consume(0, 1'b0);
      finish_tile();
      wait_done();
   endtask

   task automatic test_zero_tiles();
      apply_reset();
      start_layer(0, 7, 7, 1'b0, 'h10, 'h1);
      n_cmp++;
      if (layer_done !== 1'b0 || prod_ready !== 1'b0 || wb_valid !== 1'b0) begin
         n_err++;
         $display("FAIL zero_cycle1: got done=%b prdy=%b val=%b expected 0/0/0", layer_done,
                  prod_ready, wb_valid);
      end
      @(negedge clk);
      n_cmp++;
      if (layer_done !== 1'b1 || prod_ready !== 1'b0 || wb_valid !== 1'b0) begin
         n_err++;
         $display("FAIL zero_cycle2: got done=%b prdy=%b val=%b expected 1/0/0", layer_done,
                  prod_ready, wb_valid);
      end
      @(negedge clk);
      n_cmp++;
      if (layer_done !== 1'b0) begin
         n_err++;
         $display("FAIL zero_pulse_width: got %b expected 0", layer_done);
      end
   endtask

   task automatic test_reset_mid_layer();
      apply_reset();
      start_layer(4, 2, 3, 1'b0, 'h200, 'h10);
      produce();
      produce();
      consume(0, 1'b0);
      finish_tile();
      consume(0, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({layer_ready, layer_done, wb_valid, prod_ready, prod_bank, wb_bank} !== 6'b100000 ||
          {wb_fm_base, wb_guard_base} !== '0) begin
         n_err++;
         $display("FAIL async_reset: got rdy=%b done=%b val=%b prdy=%b fm=%h guard=%h",
                  layer_ready, layer_done, wb_valid, prod_ready, wb_fm_base, wb_guard_base);
      end
      sb.delete();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_cmp++;
         if (layer_done !== 1'b0) begin
            n_err++;
            $display("FAIL done_in_reset: got %b expected 0", layer_done);
         end
      end
      rst_n = 1'b1;
      @(negedge clk);
      start_layer(2, 1, 1, 1'b1, 'h8, 'h3);
      produce();
      consume(0, 1'b0);
      finish_tile();
      produce();
      consume(0, 1'b0);
      finish_tile();
      wait_done();
      n_cmp++;
      if (wb_fm_base !== 16'h000e || wb_guard_base !== 14'h3) begin
         n_err++;
         $display("FAIL fresh_final_bases: got fm=%h guard=%h expected 000e/0003", wb_fm_base,
                  wb_guard_base);
      end
   endtask

   initial begin
      test_reset();
      test_single_tile();
      test_bank_sequence();
      test_both_full();
      test_ready_stall();
      test_zero_tiles();
      test_reset_mid_layer();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
      $fatal(1);
   end

endmodule

// File: doc/psum_wb_scheduler.md
Name: psum_wb_scheduler

Overview:
Layer-level sequencer for the ReLU/guard write-back engine. It owns two ping-pong psum banks shared between the PE-array producer and the write-back engine, and it counts tiles in a layer. For each filled bank it issues one write-back start with the tile dimensions, the bit mode and the fm/guard destination base addresses. After each engine finish it frees the bank and advances the base addresses.

Parameters:
CNT_W, 8, width of the layer tile counter
FM_ADDR_W, 16, feature-map buffer byte address width
GUARD_ADDR_W, 14, guard buffer address width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
layer_valid  in  1  layer descriptor valid
layer_ready  out  1  scheduler idle; accepts descriptor
layer_tiles_i  in  CNT_W  number of tiles in the layer
w_num_i  in  8  tile width, 1..255
h_num_i  in  8  tile height, 1..255
bit_mode_i  in  1  1 = 4-bit packed output, 0 = 8-bit output with guard
fm_base_i  in  FM_ADDR_W  first fm write address
guard_base_i  in  GUARD_ADDR_W  first guard write address
layer_done  out  1  one-cycle pulse, layer complete
prod_ready  out  1  producer may fill bank prod_bank
prod_bank  out  1  bank index for the producer
prod_done  in  1  pulse: producer finished prod_bank (honoured only while prod_ready)
wb_valid  out  1  write-back start request
wb_ready  in  1  engine ready
wb_finish  in  1  engine finish pulse
wb_w_num  out  8  tile width to the engine
wb_h_num  out  8  tile height to the engine
wb_bit_mode  out  1  bit mode to the engine
wb_bank  out  1  psum bank the engine reads
wb_fm_base  out  FM_ADDR_W  fm base address for the current tile
wb_guard_base  out  GUARD_ADDR_W  guard base address for the current tile

Behaviour:
- Reset values:
  - FSM = IDLE; layer_ready = 1.
  - layer_done, wb_valid, prod_ready = 0.
  - Bank full flags = 00; prod_ptr = wb_ptr = 0.
  - All counters, bases and dimension registers = 0.
- A reset asserted mid-layer abandons the layer: no layer_done, banks are freed.
- FSM states: IDLE, ISSUE, RUN, DONE.
- IDLE:
  - When layer_valid && layer_ready, latch w, h, bit_mode, tiles, fm_base, guard_base.
  - Compute pix = w*h (16-bit product, registered).
  - fm_step = bit_mode ? pix*3 : pix*6, truncated to FM_ADDR_W. guard_step = bit_mode ? 0 : pix.
  - Clear issued/done counters. layer_ready drops the next cycle.
  - If tiles == 0, go to DONE; otherwise go to ISSUE. The pix/step registers settle before the first wb_valid.
- Producer side, active in ISSUE and RUN:
  - prod_ready = !full[prod_ptr] && issued_cnt < tiles.
  - On prod_done && prod_ready: set full[prod_ptr], toggle prod_ptr, increment issued_cnt.
  - prod_done while prod_ready = 0 is ignored.
- ISSUE:
  - wb_valid = full[wb_ptr], registered; it goes high the cycle after the bank becomes full.
  - wb_valid is held, with all wb_* fields stable, until wb_ready.
  - On wb_valid && wb_ready: wb_valid = 0 next cycle, go to RUN.
- RUN:
  - Wait for wb_finish. wb_finish seen in any other state is ignored.
  - On wb_finish:
    - Clear full[wb_ptr] and toggle wb_ptr.
    - fm_base += fm_step; guard_base += guard_step (both wrap modulo 2^width).
    - Increment done_cnt.
  - If done_cnt + 1 == tiles, go to DONE; otherwise go to ISSUE.
- DONE: layer_done = 1 for exactly one cycle, layer_ready = 1, go to IDLE.
- Same-cycle events:
  - prod_done and wb_finish always act on different banks (wb_ptr bank is full, prod_ptr bank is empty). Both updates apply in that cycle.
  - A bank freed by wb_finish may be granted to the producer on the next cycle, not the same cycle.
- Throughput: both banks may be full at once. The producer then stalls (prod_ready = 0) until a finish.
- Latency: wb_finish to the next wb_valid is 2 cycles when the other bank is already full.
- wb_w_num, wb_h_num and wb_bit_mode are constant for the whole layer. A new descriptor is accepted only in IDLE.

Test Plan:
1. Reset, then tiles=1, w=4, h=2, bit_mode=0, fm_base=0x100, guard_base=0x20. Producer prod_done on bank 0. → wb_valid with wb_bank=0, fm_base 0x100, guard_base 0x20. After wb_finish: one layer_done pulse, final fm_base 0x130, guard_base 0x28.
2. tiles=3, w=2, h=2, bit_mode=1, fm_base=0. → wb_bank sequence 0,1,0 with wb_fm_base 0, 12, 24 and wb_guard_base unchanged. prod_ready returns only after the matching finish.
3. Producer fills both banks before the first finish. → prod_ready = 0 until wb_finish. Next wb_valid appears 2 cycles after the finish with wb_bank=1.
4. wb_ready held low 5 cycles. → wb_valid and all wb_* fields stable throughout. A spurious wb_finish during ISSUE does not advance the tile count.
5. tiles=0. → layer_done pulses 2 cycles after acceptance; no prod_ready, no wb_valid.
6. rst_n asserted during RUN of tile 2 of 4. → All outputs return to reset values immediately with no layer_done. A fresh layer then runs normally, starting from bank 0.
